task_ctrl_param: RTL and testbench

//  Parametrised per-task control block: replaces the fixed single-ID task FSMs.

---
 rtl/task_ctrl_param.sv | 144 ++++++++++++++
 tb/tb_task_ctrl_param.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/task_ctrl_param.sv
// Per-task scheduler control block: decodes ops addressed to TASK_ID, tracks state, hits and priority.
// Define TASK_AGING_EN to enable READY-state priority aging (age counter); otherwise priority only changes via ops.
//
// state | meaning
// READY | runnable, presented to the priority sorter, priority ages
// SUSP  | suspended by scheduler
// WAIT  | blocked waiting on an event
// TERM  | terminated, absorbing until reset
// RUN   | currently executing
module task_ctrl_param #(
  parameter int TASK_ID    = 4,
  parameter int ID_W       = 4,
  parameter int PRIO_W     = 4,
  parameter int HIT_W      = 8,
  parameter int HIT_INIT   = 128,
  parameter int AGE_PERIOD = 10000
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   op_valid,
  input  logic [15:0]            in_op,
  output logic [ID_W+PRIO_W-1:0] out_sorter,
  output logic [2:0]             state_o,
  output logic [HIT_W-1:0]       exe_hit_o,
  output logic                   op_err
);

  typedef enum logic [2:0] {
    ST_READY = 3'b000,
    ST_SUSP  = 3'b001,
    ST_WAIT  = 3'b010,
    ST_TERM  = 3'b011,
    ST_RUN   = 3'b100
  } state_t;

  localparam logic [ID_W-1:0]   ID_L     = ID_W'(TASK_ID);
  localparam logic [PRIO_W-1:0] PRIO_MAX = '1;

  state_t              state, state_nx;
  logic [PRIO_W-1:0]   prio, prio_nx;
  logic [HIT_W-1:0]    hit, hit_nx;
  logic                err_nx;
  logic                addressed, accept, age_clr;
  logic [3:0]          opcode, data;

  assign addressed = op_valid && (in_op[8 +: ID_W] == ID_L);
  assign opcode    = in_op[7:4];
  assign data      = in_op[3:0];

`ifdef TASK_AGING_EN
  localparam int               AGE_W    = (AGE_PERIOD > 2) ? $clog2(AGE_PERIOD) : 1;
  localparam logic [AGE_W-1:0] AGE_LAST = AGE_W'(AGE_PERIOD - 1);
  logic [AGE_W-1:0] age, age_nx;
  logic             unused_ok;
  assign unused_ok = ^in_op;
`else
  logic unused_ok;
  assign unused_ok = ^{in_op, accept, age_clr, 32'(AGE_PERIOD)};
`endif

  always_comb begin
    state_nx = state;
    prio_nx  = prio;
    hit_nx   = hit;
    err_nx   = 1'b0;
    accept   = 1'b0;
    age_clr  = 1'b0;
    if (addressed) begin
      if (state == ST_TERM) begin
        err_nx = 1'b1;
      end else begin
        unique case (opcode)
          4'h1: if (state == ST_SUSP || state == ST_WAIT) begin
                  state_nx = ST_READY; age_clr = 1'b1; accept = 1'b1;
                end else err_nx = 1'b1;
          4'h2: if (state == ST_READY || state == ST_RUN) begin
                  state_nx = ST_SUSP; accept = 1'b1;
                end else err_nx = 1'b1;
          4'h3: if (state == ST_READY || state == ST_RUN) begin
                  state_nx = ST_WAIT; accept = 1'b1;
                end else err_nx = 1'b1;
          4'h4, 4'hC: begin
                  state_nx = ST_TERM; accept = 1'b1;
                end
          4'h5: begin
                  prio_nx = PRIO_W'(data); age_clr = 1'b1; accept = 1'b1;
                end
          4'h6: begin
                  hit_nx = HIT_W'(data); accept = 1'b1;
                end
          4'h7: if (state == ST_READY && hit != '0) begin
                  state_nx = ST_RUN; hit_nx = hit - 1'b1; age_clr = 1'b1; accept = 1'b1;
                end else err_nx = 1'b1;
          4'hF: if (state == ST_RUN) begin
                  state_nx = (hit != '0) ? ST_READY : ST_TERM;
                  prio_nx  = '0;
                  accept   = 1'b1;
                end else err_nx = 1'b1;
          default: err_nx = 1'b1;
        endcase
      end
    end
`ifdef TASK_AGING_EN
    // An accepted op in the tick cycle swallows the tick and restarts the period.
    age_nx = age;
    if (age_clr) begin
      age_nx = '0;
    end else if (state == ST_READY) begin
      if (age == AGE_LAST) begin
        age_nx = '0;
        if (!accept && prio != PRIO_MAX) prio_nx = prio + 1'b1;
      end else begin
        age_nx = age + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= ST_READY;
      prio       <= '0;
      hit        <= HIT_W'(HIT_INIT);
      op_err     <= 1'b0;
      out_sorter <= '0;
`ifdef TASK_AGING_EN
      age        <= '0;
`endif
    end else begin
      state      <= state_nx;
      prio       <= prio_nx;
      hit        <= hit_nx;
      op_err     <= err_nx;
      out_sorter <= (state_nx == ST_READY) ? {ID_L, prio_nx} : '0;
`ifdef TASK_AGING_EN
      age        <= age_nx;
`endif
    end
  end

  assign state_o   = state;
  assign exe_hit_o = hit;

endmodule

// File: tb/tb_task_ctrl_param.sv
// Directed table-driven bench for task_ctrl_param (TASK_ID=4, AGE_PERIOD=4).
module tb_task_ctrl_param;

  logic        CLK;
  logic        RST_N;
  logic        op_valid;
  logic [15:0] in_op;
  logic [7:0]  out_sorter;
  logic [2:0]  state_o;
  logic [7:0]  exe_hit_o;
  logic        op_err;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef TASK_AGING_EN
  localparam bit AGING = 1'b1;
`else
  localparam bit AGING = 1'b0;
`endif

  task_ctrl_param #(
    .TASK_ID(4), .ID_W(4), .PRIO_W(4), .HIT_W(8), .HIT_INIT(128), .AGE_PERIOD(4)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .op_valid(op_valid), .in_op(in_op),
    .out_sorter(out_sorter), .state_o(state_o), .exe_hit_o(exe_hit_o), .op_err(op_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        v;
    logic [15:0] op;
    logic [2:0]  st;
    logic [7:0]  hit;
    logic [7:0]  srt;
    logic        err;
  } vec_t;

  vec_t tbl[25];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic v, input logic [15:0] op);
    @(negedge CLK);
    op_valid = v;
    in_op    = op;
    @(posedge CLK);
    #1;
    op_valid = 1'b0;
    in_op    = 16'h0000;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 16'h0000);
  endtask

  task automatic async_reset(input string tag);
    #2;
    RST_N = 1'b0;
    #1;
    check({tag, "_state"}, 32'(state_o), 32'd0);
    check({tag, "_hit"}, 32'(exe_hit_o), 32'd128);
    check({tag, "_sorter"}, 32'(out_sorter), 32'h0);
    check({tag, "_err"}, 32'(op_err), 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  initial begin
    // v, op, state, hits, sorter, err
    tbl[0]  = '{1'b1, 16'h0471, 3'd4, 8'd127, 8'h00, 1'b0};
    tbl[1]  = '{1'b1, 16'h04F0, 3'd0, 8'd127, 8'h40, 1'b0};
    tbl[2]  = '{1'b1, 16'h0451, 3'd0, 8'd127, 8'h41, 1'b0};
    tbl[3]  = '{1'b1, 16'h0572, 3'd0, 8'd127, 8'h41, 1'b0};
    tbl[4]  = '{1'b1, 16'h0460, 3'd0, 8'd0,   8'h41, 1'b0};
    tbl[5]  = '{1'b1, 16'h0470, 3'd0, 8'd0,   8'h41, 1'b1};
    tbl[6]  = '{1'b1, 16'h0452, 3'd0, 8'd0,   8'h42, 1'b0};
    tbl[7]  = '{1'b1, 16'h0463, 3'd0, 8'd3,   8'h42, 1'b0};
    tbl[8]  = '{1'b1, 16'h0420, 3'd1, 8'd3,   8'h00, 1'b0};
    tbl[9]  = '{1'b1, 16'h0420, 3'd1, 8'd3,   8'h00, 1'b1};
    tbl[10] = '{1'b1, 16'h0410, 3'd0, 8'd3,   8'h42, 1'b0};
    tbl[11] = '{1'b1, 16'h0430, 3'd2, 8'd3,   8'h00, 1'b0};
    tbl[12] = '{1'b1, 16'h0470, 3'd2, 8'd3,   8'h00, 1'b1};
    tbl[13] = '{1'b1, 16'h0410, 3'd0, 8'd3,   8'h42, 1'b0};
    tbl[14] = '{1'b1, 16'h0480, 3'd0, 8'd3,   8'h42, 1'b1};
    tbl[15] = '{1'b1, 16'h0471, 3'd4, 8'd2,   8'h00, 1'b0};
    tbl[16] = '{1'b1, 16'h0430, 3'd2, 8'd2,   8'h00, 1'b0};
    tbl[17] = '{1'b1, 16'h0410, 3'd0, 8'd2,   8'h42, 1'b0};
    tbl[18] = '{1'b1, 16'h0471, 3'd4, 8'd1,   8'h00, 1'b0};
    tbl[19] = '{1'b1, 16'h0420, 3'd1, 8'd1,   8'h00, 1'b0};
    tbl[20] = '{1'b1, 16'h04F0, 3'd1, 8'd1,   8'h00, 1'b1};
    tbl[21] = '{1'b1, 16'h04C0, 3'd3, 8'd1,   8'h00, 1'b0};
    tbl[22] = '{1'b1, 16'h0410, 3'd3, 8'd1,   8'h00, 1'b1};
    tbl[23] = '{1'b1, 16'h0451, 3'd3, 8'd1,   8'h00, 1'b1};
    tbl[24] = '{1'b0, 16'h0000, 3'd3, 8'd1,   8'h00, 1'b0};

    RST_N    = 1'b0;
    op_valid = 1'b0;
    in_op    = 16'h0000;
    #12;
    check("rst_state", 32'(state_o), 32'd0);
    check("rst_hit", 32'(exe_hit_o), 32'd128);
    check("rst_sorter", 32'(out_sorter), 32'h0);
    check("rst_err", 32'(op_err), 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;

    for (int i = 0; i < 25; i++) begin
      step(tbl[i].v, tbl[i].op);
      check($sformatf("row%0d_state", i), 32'(state_o), 32'(tbl[i].st));
      check($sformatf("row%0d_hit", i), 32'(exe_hit_o), 32'(tbl[i].hit));
      check($sformatf("row%0d_sorter", i), 32'(out_sorter), 32'(tbl[i].srt));
      check($sformatf("row%0d_err", i), 32'(op_err), 32'(tbl[i].err));
    end

    async_reset("term_rst");

    // FINISH with no hits left terminates
    step(1'b1, 16'h0461);
    step(1'b1, 16'h0471);
    check("fin0_run", 32'(state_o), 32'd4);
    check("fin0_hit", 32'(exe_hit_o), 32'd0);
    step(1'b1, 16'h04F0);
    check("fin0_state", 32'(state_o), 32'd3);
    check("fin0_sorter", 32'(out_sorter), 32'h0);
    check("fin0_err", 32'(op_err), 32'd0);

    async_reset("fin0_rst");

    // FINISH with hits remaining returns to READY with prio cleared
    step(1'b1, 16'h0455);
    check("fin3_prio", 32'(out_sorter), 32'h45);
    step(1'b1, 16'h0464);
    step(1'b1, 16'h0471);
    check("fin3_run", 32'(state_o), 32'd4);
    check("fin3_hit", 32'(exe_hit_o), 32'd3);
    check("fin3_run_sorter", 32'(out_sorter), 32'h0);
    step(1'b1, 16'h04F0);
    check("fin3_state", 32'(state_o), 32'd0);
    check("fin3_hit2", 32'(exe_hit_o), 32'd3);
    check("fin3_sorter", 32'(out_sorter), 32'h40);

    // Aging saturation
    step(1'b1, 16'h045E);
    check("age_set14", 32'(out_sorter), 32'h4E);
    idle(3);
    check("age_3cyc", 32'(out_sorter), 32'h4E);
    idle(1);
    check("age_4cyc", 32'(out_sorter), AGING ? 32'h4F : 32'h4E);
    idle(4);
    check("age_8cyc", 32'(out_sorter), AGING ? 32'h4F : 32'h4E);

    // Accepted op in the tick cycle drops the tick and restarts the period
    step(1'b1, 16'h0453);
    idle(3);
    check("tick_pre", 32'(out_sorter), 32'h43);
    step(1'b1, 16'h0465);
    check("tick_drop", 32'(out_sorter), 32'h43);
    check("tick_hit", 32'(exe_hit_o), 32'd5);
    idle(3);
    check("tick_restart3", 32'(out_sorter), 32'h43);
    idle(1);
    check("tick_restart4", 32'(out_sorter), AGING ? 32'h44 : 32'h43);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
